dmem_responder: RTL

Responder end of the MEM-stage data-memory interface: accepts one load/store request at a time over a valid/ready handshake and services it against an internal 64-bit-word array after a configurable latency. It returns a response on a second valid/ready channel. Loads return the sized, sign/zero-extended value; stores return an acknowledge. It replaces the zero-latency data memory behind the MEM stage and allows multi-cycle memory to be modelled.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder_lane_align.sv | 58 +++++
 rtl/dmem_responder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types for the MEM-stage data-memory responder
// Purpose: access-size and FSM-state enums, latched-request struct, counter width.
// Ports: none (package dmem_pkg).
// Optional feature macro used by the slice: DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        write;
    mem_size_e   size;
    logic        is_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
  } dmem_req_t;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle for the data-memory responder
// Purpose: groups the request channel (req_*) and response channel (rsp_*).
// Ports (signals): req_valid/req_ready/req_write/req_size/req_unsigned/req_addr/req_wdata,
//                  rsp_valid/rsp_ready/rsp_rdata/rsp_err.
// Modports: master = MEM-stage requester, slave = dmem_responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// rtl/dmem_responder_lane_align.sv - combinational byte-lane steering for the data-memory responder
// Purpose: byte-write mask, shifted store data, extracted/extended load data, misalign flag.
// Ports: i_size, i_offset, i_unsigned, i_wdata, i_word -> o_be, o_wdata, o_rdata, o_misalign.
// Macro: DMEM_MISALIGN_CHECK_EN keeps the raw offset (misaligned accesses are flagged upstream);
//        without it the offset is rounded down to the access size.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic [2:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_word,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata,
  output logic        o_misalign
);

  logic [2:0]  w_amask;
  logic [7:0]  w_base;
  logic [2:0]  w_off;
  logic [63:0] w_raw;

  always_comb begin
    w_amask = 3'b000;
    w_base  = 8'h01;
    case (i_size)
      SZ_B: begin w_amask = 3'b000; w_base = 8'h01; end
      SZ_H: begin w_amask = 3'b001; w_base = 8'h03; end
      SZ_W: begin w_amask = 3'b011; w_base = 8'h0F; end
      SZ_D: begin w_amask = 3'b111; w_base = 8'hFF; end
      default: ;
    endcase

    o_misalign = |(i_offset & w_amask);
`ifdef DMEM_MISALIGN_CHECK_EN
    w_off = i_offset;
`else
    w_off = i_offset & ~w_amask;
`endif

    // Wide shift then truncate: a flagged misaligned access may push lanes past byte 7.
    o_be    = 8'({8'h00, w_base} << w_off);
    o_wdata = i_wdata << {w_off, 3'b000};
    w_raw   = i_word >> {w_off, 3'b000};

    o_rdata = w_raw;
    case (i_size)
      SZ_B: o_rdata = i_unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      SZ_H: o_rdata = i_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      SZ_W: o_rdata = i_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      SZ_D: o_rdata = w_raw;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable responder end of the MEM-stage data-memory interface
// Purpose: one outstanding load/store, serviced against a DEPTH_WORDS x 64-bit array,
//          response LATENCY cycles after accept (counting the accept cycle as 0).
// Ports: clk, reset (async, active-high), bus (dmem_responder_if.slave: req_* in, rsp_* out,
//        req_ready/rsp_valid decoded from state).
// Macro: DMEM_MISALIGN_CHECK_EN enables misaligned-access error responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e            r_state;
  logic [LAT_CNT_W-1:0]   r_cnt;
  dmem_req_t              r_req;
  logic [63:0]            r_rdata;
  logic                   r_err;
  logic [63:0]            r_mem [DEPTH_WORDS];

  dmem_req_t              w_live;
  dmem_req_t              w_req;
  logic                   w_accept;
  logic                   w_commit;
  logic [IDX_W-1:0]       w_idx;
  logic [7:0]             w_be;
  logic [63:0]            w_wsh;
  logic [63:0]            w_rd;
  logic                   w_misalign;
  logic                   w_err;
  logic [63:0]            w_rsp_data;
  logic                   w_unused;

  assign w_live.write       = bus.req_write;
  assign w_live.size        = mem_size_e'(bus.req_size);
  assign w_live.is_unsigned = bus.req_unsigned;
  assign w_live.addr        = bus.req_addr;
  assign w_live.wdata       = bus.req_wdata;

  // With LATENCY==1 the commit edge is the accept edge, so the live request must be used.
  assign w_req    = (r_state == IDLE) ? w_live : r_req;
  assign w_accept = bus.req_valid && (r_state == IDLE);
  assign w_commit = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt == '0));
  assign w_idx    = w_req.addr[IDX_W+2:3];

  dmem_lane_align u_lane (
    .i_size     (w_req.size),
    .i_offset   (w_req.addr[2:0]),
    .i_unsigned (w_req.is_unsigned),
    .i_wdata    (w_req.wdata),
    .i_word     (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wdata    (w_wsh),
    .o_rdata    (w_rd),
    .o_misalign (w_misalign)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_err = w_misalign;
`else
  assign w_err = 1'b0;
`endif

  assign w_rsp_data = (w_req.write || w_err) ? 64'd0 : w_rd;
  assign w_unused   = ^{w_req.addr[63:IDX_W+3], w_misalign};

  // Array is deliberately not reset; reset only blocks a commit from landing.
  always_ff @(posedge clk) begin
    if (w_commit && !reset && w_req.write && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req <= w_live;
            if (LATENCY > 1) begin
              r_state <= WAIT;
              r_cnt   <= LAT_CNT_W'(LATENCY - 2);
            end else begin
              r_state <= RESP;
              r_rdata <= w_rsp_data;
              r_err   <= w_err;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            r_rdata <= w_rsp_data;
            r_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state <= IDLE;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
